// File: rtl/inst_fetch_unit.sv
// Instruction fetch unit: one outstanding memory read at a time feeding a two-entry {instruction, pc} buffer.
// Optional HLT detection and HALT state are built only when FETCH_HALT_DETECT_EN is defined.
module inst_fetch_unit (
    input  logic        clock,
    input  logic        reset,
    output logic        mem_req,
    output logic [15:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    input  logic        PC_load,
    input  logic [15:0] branchTarget,
    input  logic        stall,
    output logic [15:0] COMMAND,
    output logic        cmd_valid,
    output logic [15:0] cmd_pc,
    output logic        halted
);

`ifdef FETCH_HALT_DETECT_EN
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DROP = 2'd2, ST_HALT = 2'd3} state_t;

    function automatic logic is_hlt(input logic [15:0] word);
        return (word[15:14] == 2'b11) && (word[7:4] == 4'b1111);
    endfunction
`else
    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_WAIT = 2'd1, ST_DROP = 2'd2} state_t;
`endif

    state_t      state_r, state_s;
    logic        mem_req_r, mem_req_s;
    logic [15:0] mem_addr_r, mem_addr_s;
    logic [15:0] fetch_pc_r, fetch_pc_s;
    logic        fetch_stop_r, fetch_stop_s;
    logic [1:0]  cnt_r, cnt_s;
    logic        cmd_valid_r, cmd_valid_s;
    logic [15:0] ins0_r, ins0_s, pc0_r, pc0_s;
    logic [15:0] ins1_r, ins1_s, pc1_r, pc1_s;
    logic        in_halt_s, redirect_s, pop_s, push_s, hlt_push_s, space_s;
    logic [15:0] next_addr_s;
`ifdef FETCH_HALT_DETECT_EN
    logic        halted_r, halted_s, hlt_retire_s;
`endif

    // Next-state, buffer and request logic
    always_comb begin
        state_s      = state_r;
        mem_addr_s   = mem_addr_r;
        fetch_pc_s   = fetch_pc_r;
        fetch_stop_s = fetch_stop_r;
        cnt_s        = cnt_r;
        ins0_s       = ins0_r;
        pc0_s        = pc0_r;
        ins1_s       = ins1_r;
        pc1_s        = pc1_r;
        in_halt_s    = 1'b0;
        hlt_push_s   = 1'b0;
        next_addr_s  = mem_addr_r + 16'd1;
`ifdef FETCH_HALT_DETECT_EN
        in_halt_s    = (state_r == ST_HALT);
`endif
        redirect_s   = PC_load && !in_halt_s;
        pop_s        = cmd_valid_r && !stall && !redirect_s && !in_halt_s;
        push_s       = (state_r == ST_WAIT) && mem_ack && !redirect_s;
`ifdef FETCH_HALT_DETECT_EN
        hlt_push_s   = push_s && is_hlt(mem_rdata);
        hlt_retire_s = pop_s && is_hlt(ins0_r);
`endif

        // Unused buffer slots are kept at zero so the head reads 0 when empty
        if (redirect_s) begin
            cnt_s  = 2'd0;
            ins0_s = 16'd0;
            pc0_s  = 16'd0;
            ins1_s = 16'd0;
            pc1_s  = 16'd0;
        end else begin
            case ({push_s, pop_s})
                2'b01: begin
                    ins0_s = ins1_r;
                    pc0_s  = pc1_r;
                    ins1_s = 16'd0;
                    pc1_s  = 16'd0;
                    cnt_s  = cnt_r - 2'd1;
                end
                2'b10: begin
                    if (cnt_r == 2'd0) begin
                        ins0_s = mem_rdata;
                        pc0_s  = mem_addr_r;
                    end else begin
                        ins1_s = mem_rdata;
                        pc1_s  = mem_addr_r;
                    end
                    cnt_s = cnt_r + 2'd1;
                end
                2'b11: begin
                    if (cnt_r == 2'd1) begin
                        ins0_s = mem_rdata;
                        pc0_s  = mem_addr_r;
                    end else begin
                        ins0_s = ins1_r;
                        pc0_s  = pc1_r;
                        ins1_s = mem_rdata;
                        pc1_s  = mem_addr_r;
                    end
                end
                default: begin
                    cnt_s = cnt_r;
                end
            endcase
        end

        if (redirect_s) begin
            fetch_stop_s = 1'b0;
        end else if (hlt_push_s) begin
            fetch_stop_s = 1'b1;
        end else begin
            fetch_stop_s = fetch_stop_r;
        end

        space_s = (cnt_s != 2'd2) && !fetch_stop_s;

        case (state_r)
            ST_IDLE: begin
                if (redirect_s) begin
                    fetch_pc_s = branchTarget;
                    mem_addr_s = branchTarget;
                    state_s    = ST_WAIT;
`ifdef FETCH_HALT_DETECT_EN
                end else if (hlt_retire_s) begin
                    state_s = ST_HALT;
`endif
                end else if (space_s) begin
                    mem_addr_s = fetch_pc_r;
                    state_s    = ST_WAIT;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (mem_ack && redirect_s) begin
                    fetch_pc_s = branchTarget;
                    mem_addr_s = branchTarget;
                    state_s    = ST_WAIT;
                end else if (mem_ack) begin
                    fetch_pc_s = next_addr_s;
                    if (space_s) begin
                        mem_addr_s = next_addr_s;
                        state_s    = ST_WAIT;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else if (redirect_s) begin
                    fetch_pc_s = branchTarget;
                    state_s    = ST_DROP;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            // The in-flight word is discarded; the most recent redirect target is fetched next
            ST_DROP: begin
                if (redirect_s) begin
                    fetch_pc_s = branchTarget;
                end else begin
                    fetch_pc_s = fetch_pc_r;
                end
                if (mem_ack) begin
                    mem_addr_s = redirect_s ? branchTarget : fetch_pc_r;
                    state_s    = ST_WAIT;
                end else begin
                    state_s = ST_DROP;
                end
            end
`ifdef FETCH_HALT_DETECT_EN
            ST_HALT: begin
                state_s = ST_HALT;
            end
`endif
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        mem_req_s   = (state_s == ST_WAIT) || (state_s == ST_DROP);
        cmd_valid_s = (cnt_s != 2'd0);
`ifdef FETCH_HALT_DETECT_EN
        halted_s    = (state_s == ST_HALT);
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 16'd0;
            fetch_pc_r   <= 16'd0;
            fetch_stop_r <= 1'b0;
            cnt_r        <= 2'd0;
            cmd_valid_r  <= 1'b0;
            ins0_r       <= 16'd0;
            pc0_r        <= 16'd0;
            ins1_r       <= 16'd0;
            pc1_r        <= 16'd0;
`ifdef FETCH_HALT_DETECT_EN
            halted_r     <= 1'b0;
`endif
        end else begin
            state_r      <= state_s;
            mem_req_r    <= mem_req_s;
            mem_addr_r   <= mem_addr_s;
            fetch_pc_r   <= fetch_pc_s;
            fetch_stop_r <= fetch_stop_s;
            cnt_r        <= cnt_s;
            cmd_valid_r  <= cmd_valid_s;
            ins0_r       <= ins0_s;
            pc0_r        <= pc0_s;
            ins1_r       <= ins1_s;
            pc1_r        <= pc1_s;
`ifdef FETCH_HALT_DETECT_EN
            halted_r     <= halted_s;
`endif
        end
    end

    assign mem_req   = mem_req_r;
    assign mem_addr  = mem_addr_r;
    assign cmd_valid = cmd_valid_r;
    assign COMMAND   = ins0_r;
    assign cmd_pc    = pc0_r;
`ifdef FETCH_HALT_DETECT_EN
    assign halted    = halted_r;
`else
    assign halted    = 1'b0;
`endif

endmodule

// File: doc/inst_fetch_unit.md
INST_FETCH_UNIT -- requirements
Module: inst_fetch_unit

Interface
REQ-001 Clock and reset: one clock; reset is synchronous and active-high.
REQ-002 clock  input  1  sole clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 mem_req  output  1  instruction-memory read request; held until mem_ack.
REQ-005 mem_addr  output  16  word address of the request; stable while mem_req=1.
REQ-006 mem_ack  input  1  request accepted and mem_rdata valid this cycle.
REQ-007 mem_rdata  input  16  instruction word; sampled only when mem_req=1 and mem_ack=1.
REQ-008 PC_load  input  1  redirect from the branch unit: refetch from branchTarget.
REQ-009 branchTarget  input  16  redirect address; sampled when PC_load=1.
REQ-010 stall  input  1  decode stage not ready; the presented COMMAND is held.
REQ-011 COMMAND  output  16  instruction presented to the decode stage (head of buffer).
REQ-012 cmd_valid  output  1  COMMAND and cmd_pc are valid.
REQ-013 cmd_pc  output  16  address COMMAND was fetched from.
REQ-014 halted  output  1  HLT retired; fetch permanently stopped until reset.

Function
REQ-015 FSM states: IDLE (no request outstanding), WAIT (request outstanding), DROP (outstanding request whose data is discarded), HALT.
REQ-016 Two-entry FIFO of {instruction, pc}; COMMAND/cmd_pc = head entry; cmd_valid = FIFO not empty; COMMAND=0 and cmd_pc=0 when empty.
REQ-017 IDLE->WAIT when occupancy is below 2 and fetch is not stopped: mem_req=1, mem_addr=fetch_pc at the next edge.
REQ-018 WAIT with mem_ack=1: data pushed to the FIFO with pc=mem_addr, fetch_pc=mem_addr+1 (16-bit, 16'hFFFF wraps to 0); next state WAIT (new request) if space remains after push and pop, else IDLE.
REQ-019 Latency: mem_ack in cycle N with an empty FIFO -> cmd_valid=1 with that word in cycle N+1.
REQ-020 Head retires when cmd_valid=1 and stall=0; a push and a pop may occur in the same cycle.
REQ-021 mem_req is never dropped and mem_addr never changes before mem_ack, including during PC_load.
REQ-022 PC_load=1: FIFO flushed (cmd_valid=0 next cycle), fetch_pc=branchTarget, fetch-stop cleared; retire and push in that cycle are discarded.
REQ-023 PC_load during WAIT without mem_ack -> DROP; DROP holds mem_req until mem_ack, discards the data, then requests branchTarget the next cycle.
REQ-024 PC_load coincident with mem_ack -> data discarded; request for branchTarget issued the next cycle.
REQ-025 Repeated PC_load while in DROP: the latest branchTarget wins.
REQ-026 FIFO never overflows: requests are issued only when occupancy is below 2 after pending pops and pushes.
REQ-027 stall has no effect on mem_req/mem_addr other than through FIFO occupancy.

Reset
REQ-028 reset=1 at an edge: mem_req=0, mem_addr=0, cmd_valid=0, COMMAND=0, cmd_pc=0, halted=0, FIFO empty, fetch_pc=0, fetch-stop cleared, state IDLE; overrides every other input, including mid-transaction.
REQ-029 First cycle after reset release: state IDLE; second cycle: mem_req=1, mem_addr=0.
REQ-030 A mem_ack arriving for a request cancelled by reset is ignored.

Configuration
REQ-031 Macro FETCH_HALT_DETECT_EN defined: a pushed word with [15:14]=2'b11 and [7:4]=4'b1111 (HLT) sets fetch-stop, so no further requests are issued. When HLT retires, state goes to HALT and halted=1 from the next cycle. In HALT, PC_load is ignored. A PC_load before HLT retires flushes HLT and clears fetch-stop.
REQ-032 Macro absent: HLT is an ordinary instruction, the HALT state does not exist, and halted is tied to 0.

Verification
REQ-033 Reset release, mem_ack every request, stall=0 -> mem_addr 0,1,2,...; COMMAND sequence equals memory words; cmd_pc 0,1,2.
REQ-034 stall=1 for 5 cycles with words 16'hC0A6/16'h8105 acked -> FIFO full, mem_req=0, COMMAND holds 16'hC0A6; release -> 16'h8105 follows next cycle.
REQ-035 PC_load with branchTarget=16'h0040 while request to 16'h0003 outstanding, ack 3 cycles later -> that data discarded, next mem_addr=16'h0040, cmd_pc=16'h0040.
REQ-036 fetch_pc=16'hFFFF acked -> next mem_addr=16'h0000.
REQ-037 With FETCH_HALT_DETECT_EN, HLT word 16'hC0F0 at address 5 -> no request to address 7 issues, halted=1 after retire, later PC_load ignored; without macro, fetch continues and halted stays 0.
REQ-038 reset asserted while mem_req=1 -> next cycle all outputs 0, FIFO empty, and the late mem_ack is ignored.
